// File: rtl/vx_tensor_smem_bridge.sv
// Tensor-core shared-memory operand bridge.
// Merges the A and B tile-fetch request streams onto a single shared-memory
// port, tagging each request with its source, and steers responses back into
// per-source FIFOs. Per-source credits bound outstanding requests to the FIFO
// depth, so the memory response channel never needs back-pressure.
module vx_tensor_smem_bridge #(
    parameter int ADDR_WIDTH      = 32,
    parameter int TAG_WIDTH       = 4,
    parameter int DATA_WIDTH      = 256,
    parameter int RSP_QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [TAG_WIDTH-1:0]  a_req_tag,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [TAG_WIDTH-1:0]  b_req_tag,

    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [TAG_WIDTH-1:0]  a_rsp_tag,
    output logic [DATA_WIDTH-1:0] a_rsp_data,

    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [TAG_WIDTH-1:0]  b_rsp_tag,
    output logic [DATA_WIDTH-1:0] b_rsp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [TAG_WIDTH:0]    mem_req_tag,

    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [TAG_WIDTH:0]    mem_rsp_tag,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,

    output logic                  busy
);

    localparam int CNT_W = $clog2(RSP_QUEUE_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_QUEUE_DEPTH);
    localparam int PW    = PTR_W + 1;
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int ENT_W = TAG_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] CREDITS = CNT_W'(RSP_QUEUE_DEPTH);

    // Index 0 is channel A, index 1 is channel B throughout.
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [PW-1:0]    wr_q  [2];
    logic [PW-1:0]    wr_d  [2];
    logic [PW-1:0]    rd_q  [2];
    logic [PW-1:0]    rd_d  [2];
    logic [ENT_W-1:0] fifo_q [2][RSP_QUEUE_DEPTH];
    logic [ENT_W-1:0] head  [2];
    logic             rr_q;
    logic             rr_d;

    logic [1:0] req_valid;
    logic [1:0] elig;
    logic [1:0] grant;
    logic [1:0] req_fire;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [1:0] full;
    logic       rsp_src;

    assign req_valid = {b_req_valid, a_req_valid};
    assign rsp_ready = {b_rsp_ready, a_rsp_ready};
    assign rsp_src   = mem_rsp_tag[TAG_WIDTH];

    // Eligibility, round-robin grant, FIFO status and next-state for counters and pointers.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            elig[s]      = reset && req_valid[s] && (cnt_q[s] < CREDITS);
            rsp_valid[s] = (wr_q[s] != rd_q[s]);
            full[s]      = (wr_q[s][PTR_W] != rd_q[s][PTR_W]) &&
                           (wr_q[s][PTR_W-1:0] == rd_q[s][PTR_W-1:0]);
            head[s]      = fifo_q[s][rd_q[s][PTR_W-1:0]];
            push[s]      = reset && mem_rsp_valid && (rsp_src == 1'(s));
        end
        grant[0] = elig[0] && (!elig[1] || !rr_q);
        grant[1] = elig[1] && !grant[0];
        req_fire = grant & {2{mem_req_ready}};
        pop      = rsp_valid & rsp_ready;
        for (int s = 0; s < 2; s++) begin
            cnt_d[s] = cnt_q[s] + CNT_W'(req_fire[s]) - CNT_W'(pop[s]);
            wr_d[s]  = wr_q[s] + PW'(push[s]);
            rd_d[s]  = rd_q[s] + PW'(pop[s]);
        end
        rr_d = (|req_fire) ? ~rr_q : rr_q;
    end

    assign mem_req_valid = |elig;
    assign mem_req_addr  = grant[1] ? b_req_addr : a_req_addr;
    assign mem_req_tag   = grant[1] ? {1'b1, b_req_tag} : {1'b0, a_req_tag};
    assign a_req_ready   = req_fire[0];
    assign b_req_ready   = req_fire[1];

    assign a_rsp_valid = rsp_valid[0];
    assign a_rsp_tag   = head[0][ENT_W-1 -: TAG_WIDTH];
    assign a_rsp_data  = head[0][DATA_WIDTH-1:0];
    assign b_rsp_valid = rsp_valid[1];
    assign b_rsp_tag   = head[1][ENT_W-1 -: TAG_WIDTH];
    assign b_rsp_data  = head[1][DATA_WIDTH-1:0];

    assign mem_rsp_ready = reset;
    assign busy          = reset && ((cnt_q[0] != '0) || (cnt_q[1] != '0));

    // Control state: credits, FIFO pointers and round-robin pointer, cleared by async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s] <= '0;
                wr_q[s]  <= '0;
                rd_q[s]  <= '0;
            end
            rr_q <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s] <= cnt_d[s];
                wr_q[s]  <= wr_d[s];
                rd_q[s]  <= rd_d[s];
            end
            rr_q <= rr_d;
        end
    end

    // Response storage; contents need no reset because the pointers mark validity.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                fifo_q[s][wr_q[s][PTR_W-1:0]] <= {mem_rsp_tag[TAG_WIDTH-1:0], mem_rsp_data};
            end
        end
    end

    // Credit and alignment invariants that upstream/downstream must uphold.
    a_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(push[0] && full[0]) && !(push[1] && full[1]));
    a_rsp_no_credit: assert property (@(posedge clk) disable iff (!reset)
        !(push[0] && cnt_q[0] == '0) && !(push[1] && cnt_q[1] == '0));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop[0] && !req_fire[0] && cnt_q[0] == '0) && !(pop[1] && !req_fire[1] && cnt_q[1] == '0));
    a_cnt_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(req_fire[0] && !pop[0] && cnt_q[0] == CREDITS) && !(req_fire[1] && !pop[1] && cnt_q[1] == CREDITS));
    a_addr_align: assert property (@(posedge clk) disable iff (!reset)
        !(a_req_valid && a_req_addr[OFF_W-1:0] != '0) && !(b_req_valid && b_req_addr[OFF_W-1:0] != '0));

endmodule

// File: tb/tb_vx_tensor_smem_bridge.sv
// Self-checking bench for vx_tensor_smem_bridge: directed arbitration table,
// hand-written corner sequences and a randomized run against a queue-based
// reference model. The bench also plays the shared-memory side.
module tb_vx_tensor_smem_bridge;

    localparam int AW    = 32;
    localparam int TW    = 4;
    localparam int DW    = 256;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] ALIGN_MASK = 32'hFFFF_FFE0;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req_valid, a_req_ready, b_req_valid, b_req_ready;
    logic [AW-1:0] a_req_addr, b_req_addr, mem_req_addr;
    logic [TW-1:0] a_req_tag, b_req_tag, a_rsp_tag, b_rsp_tag;
    logic          a_rsp_valid, a_rsp_ready, b_rsp_valid, b_rsp_ready;
    logic [DW-1:0] a_rsp_data, b_rsp_data, mem_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready, busy;
    logic [TW:0]   mem_req_tag, mem_rsp_tag;

    always #5 clk = ~clk;

    vx_tensor_smem_bridge #(
        .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .RSP_QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr), .a_req_tag(a_req_tag),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr), .b_req_tag(b_req_tag),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_tag(a_rsp_tag), .a_rsp_data(a_rsp_data),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_tag(b_rsp_tag), .b_rsp_data(b_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    typedef struct { logic src; logic [TW-1:0] tag; int due; } pend_t;
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; } rsp_t;
    typedef struct {
        bit aV; bit bV; bit mr;
        bit expMemValid; bit expSrc; bit expAReady; bit expBReady; bit expBusy;
    } vec_t;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: outstanding credits, preferred source, expected response queues
    int    cntA, cntB;
    bit    ptrB;
    rsp_t  qA[$];
    rsp_t  qB[$];
    pend_t pend[$];
    int    cycleNo;
    int    memLat;
    bit    memAuto;
    bit    lastFireA, lastFireB;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    task automatic resetModel();
        cntA = 0; cntB = 0; ptrB = 1'b0;
        qA.delete(); qB.delete(); pend.delete();
        lastFireA = 1'b0; lastFireB = 1'b0;
    endtask

    // Called at a falling edge: drives memory response, checks outputs, advances model at rising edge
    task automatic runCycle();
        bit eA, eB, gA, gB, expValid, popA, popB, rspNow;
        logic [DW-1:0] d;
        pend_t p;
        rsp_t r;
        if (memAuto && pend.size() > 0 && pend[0].due <= cycleNo) begin
            p = pend[0];
            for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = {p.src, p.tag};
            mem_rsp_data  = d;
        end else begin
            mem_rsp_valid = 1'b0;
        end
        #1;
        eA = a_req_valid && (cntA < DEPTH);
        eB = b_req_valid && (cntB < DEPTH);
        gA = eA && (!eB || !ptrB);
        gB = eB && !gA;
        expValid = eA || eB;
        checkOutput("mem_req_valid", mem_req_valid, expValid);
        if (expValid) begin
            checkOutput("mem_req_addr", mem_req_addr, gB ? b_req_addr : a_req_addr);
            checkOutput("mem_req_tag", mem_req_tag, gB ? {1'b1, b_req_tag} : {1'b0, a_req_tag});
        end
        checkOutput("a_req_ready", a_req_ready, gA && mem_req_ready);
        checkOutput("b_req_ready", b_req_ready, gB && mem_req_ready);
        checkOutput("a_rsp_valid", a_rsp_valid, qA.size() > 0);
        if (qA.size() > 0) begin
            checkOutput("a_rsp_tag", a_rsp_tag, qA[0].tag);
            checkOutput("a_rsp_data", a_rsp_data, qA[0].data);
        end
        checkOutput("b_rsp_valid", b_rsp_valid, qB.size() > 0);
        if (qB.size() > 0) begin
            checkOutput("b_rsp_tag", b_rsp_tag, qB[0].tag);
            checkOutput("b_rsp_data", b_rsp_data, qB[0].data);
        end
        checkOutput("mem_rsp_ready", mem_rsp_ready, 1'b1);
        checkOutput("busy", busy, (cntA != 0) || (cntB != 0));
        popA = (qA.size() > 0) && a_rsp_ready;
        popB = (qB.size() > 0) && b_rsp_ready;
        rspNow = mem_rsp_valid;
        lastFireA = gA && mem_req_ready;
        lastFireB = gB && mem_req_ready;
        @(posedge clk);
        if (popA) begin void'(qA.pop_front()); cntA--; end
        if (popB) begin void'(qB.pop_front()); cntB--; end
        if (rspNow) begin
            p = pend.pop_front();
            r.tag  = p.tag;
            r.data = mem_rsp_data;
            if (p.src) qB.push_back(r); else qA.push_back(r);
        end
        if (lastFireA || lastFireB) begin
            p.src = lastFireB;
            p.tag = lastFireB ? b_req_tag : a_req_tag;
            p.due = cycleNo + memLat;
            pend.push_back(p);
            if (lastFireA) cntA++; else cntB++;
            ptrB = !ptrB;
        end
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic applyReset();
        reset = 1'b0;
        a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; memAuto = 0; memLat = 1;
        a_req_addr = '0; b_req_addr = '0; a_req_tag = '0; b_req_tag = '0;
        mem_rsp_tag = '0; mem_rsp_data = '0;
        resetModel();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Draw new random requests only where no request is currently being held
    task automatic applyStimulus();
        if (!(a_req_valid && !lastFireA)) begin
            a_req_valid = ($urandom_range(0, 2) != 0);
            a_req_addr  = $urandom() & ALIGN_MASK;
            a_req_tag   = TW'($urandom());
        end
        if (!(b_req_valid && !lastFireB)) begin
            b_req_valid = ($urandom_range(0, 2) != 0);
            b_req_addr  = $urandom() & ALIGN_MASK;
            b_req_tag   = TW'($urandom());
        end
        mem_req_ready = ($urandom_range(0, 3) != 0);
        a_rsp_ready   = $urandom_range(0, 1);
        b_rsp_ready   = $urandom_range(0, 1);
        memLat        = $urandom_range(1, 4);
    endtask

    vec_t tbl[13];
    int   issued;
    bit   fired;

    initial begin
        cycleNo = 0;
        // Outputs held low while reset is asserted, even with requests pending
        reset = 1'b0;
        resetModel();
        a_req_valid = 1; b_req_valid = 1; mem_req_ready = 1; a_rsp_ready = 1; b_rsp_ready = 1;
        a_req_addr = 32'h100; b_req_addr = 32'h200; a_req_tag = 4'd3; b_req_tag = 4'd5;
        mem_rsp_valid = 0; mem_rsp_tag = '0; mem_rsp_data = '0; memAuto = 0; memLat = 1;
        #3;
        checkOutput("rst mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("rst a_req_ready", a_req_ready, 1'b0);
        checkOutput("rst b_req_ready", b_req_ready, 1'b0);
        checkOutput("rst mem_rsp_ready", mem_rsp_ready, 1'b0);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst a_rsp_valid", a_rsp_valid, 1'b0);

        // Arbitration table from reset: stall, alternation, credit exhaustion
        //           aV bV mr  mV src aR bR busy
        tbl[0]  = '{0, 0, 1,  0, 0,  0, 0, 0};
        tbl[1]  = '{1, 1, 0,  1, 0,  0, 0, 0};
        tbl[2]  = '{1, 1, 0,  1, 0,  0, 0, 0};
        tbl[3]  = '{1, 1, 1,  1, 0,  1, 0, 0};
        tbl[4]  = '{1, 1, 1,  1, 1,  0, 1, 1};
        tbl[5]  = '{1, 1, 1,  1, 0,  1, 0, 1};
        tbl[6]  = '{1, 1, 1,  1, 1,  0, 1, 1};
        tbl[7]  = '{1, 0, 1,  1, 0,  1, 0, 1};
        tbl[8]  = '{1, 1, 1,  1, 1,  0, 1, 1};
        tbl[9]  = '{1, 1, 1,  1, 0,  1, 0, 1};
        tbl[10] = '{1, 1, 1,  1, 1,  0, 1, 1};
        tbl[11] = '{1, 1, 1,  0, 0,  0, 0, 1};
        tbl[12] = '{0, 0, 1,  0, 0,  0, 0, 1};
        applyReset();
        a_req_addr = 32'h100; b_req_addr = 32'h200; a_req_tag = 4'd3; b_req_tag = 4'd5;
        for (int i = 0; i < 13; i++) begin
            a_req_valid = tbl[i].aV; b_req_valid = tbl[i].bV; mem_req_ready = tbl[i].mr;
            #1;
            checkOutput($sformatf("tbl%0d mem_req_valid", i), mem_req_valid, tbl[i].expMemValid);
            if (tbl[i].expMemValid)
                checkOutput($sformatf("tbl%0d src", i), mem_req_tag[TW], tbl[i].expSrc);
            checkOutput($sformatf("tbl%0d a_req_ready", i), a_req_ready, tbl[i].expAReady);
            checkOutput($sformatf("tbl%0d b_req_ready", i), b_req_ready, tbl[i].expBReady);
            checkOutput($sformatf("tbl%0d busy", i), busy, tbl[i].expBusy);
            runCycle();
        end

        // Single A request, memory latency 2
        applyReset();
        memAuto = 1; memLat = 2; mem_req_ready = 1; a_rsp_ready = 1; b_rsp_ready = 1;
        a_req_valid = 1; a_req_addr = 32'h100; a_req_tag = 4'd3;
        #1;
        checkOutput("seq1 mem_req_tag", mem_req_tag, 5'b00011);
        checkOutput("seq1 mem_req_addr", mem_req_addr, 32'h100);
        runCycle();
        a_req_valid = 0;
        runCycle();
        runCycle();
        #1;
        checkOutput("seq1 a_rsp_valid", a_rsp_valid, 1'b1);
        checkOutput("seq1 a_rsp_tag", a_rsp_tag, 4'd3);
        checkOutput("seq1 busy before pop", busy, 1'b1);
        runCycle();
        #1;
        checkOutput("seq1 busy after pop", busy, 1'b0);
        checkOutput("seq1 a_rsp_valid after pop", a_rsp_valid, 1'b0);

        // Credit limit: A consumer stalled, six requests attempted
        applyReset();
        memAuto = 1; memLat = 1; mem_req_ready = 1; a_rsp_ready = 0; b_rsp_ready = 1;
        a_req_valid = 1; a_req_addr = 32'h400; a_req_tag = 4'd0;
        issued = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            fired = a_req_ready;
            if (fired) issued++;
            runCycle();
            if (fired) begin a_req_tag = a_req_tag + 4'd1; a_req_addr = a_req_addr + 32'd32; end
        end
        checkOutput("credit issued count", issued, DEPTH);
        #1;
        checkOutput("credit a_req_ready blocked", a_req_ready, 1'b0);
        checkOutput("credit a_rsp_valid", a_rsp_valid, 1'b1);
        b_req_valid = 1; b_req_addr = 32'h800; b_req_tag = 4'd9;
        #1;
        checkOutput("credit b unaffected", b_req_ready, 1'b1);
        runCycle();
        b_req_valid = 0;
        a_rsp_ready = 1;
        runCycle();
        a_rsp_ready = 0;
        #1;
        checkOutput("credit fifth issues", a_req_ready, 1'b1);
        runCycle();
        a_req_valid = 0; a_rsp_ready = 1;
        repeat (12) runCycle();
        checkOutput("credit drained busy", busy, 1'b0);

        // Reset mid-operation with two outstanding A requests and one buffered response
        applyReset();
        memAuto = 1; memLat = 1; mem_req_ready = 1; a_rsp_ready = 0; b_rsp_ready = 0;
        a_req_valid = 1; a_req_addr = 32'h100; a_req_tag = 4'd1;
        runCycle();
        a_req_addr = 32'h120; a_req_tag = 4'd2;
        runCycle();
        a_req_valid = 0;
        #1;
        checkOutput("rstmid pre a_rsp_valid", a_rsp_valid, 1'b1);
        checkOutput("rstmid pre busy", busy, 1'b1);
        a_req_valid = 1; b_req_valid = 1; b_req_addr = 32'h200; b_req_tag = 4'd6;
        mem_rsp_valid = 0;
        reset = 1'b0;
        #1;
        checkOutput("rstmid mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("rstmid a_req_ready", a_req_ready, 1'b0);
        checkOutput("rstmid b_req_ready", b_req_ready, 1'b0);
        checkOutput("rstmid a_rsp_valid", a_rsp_valid, 1'b0);
        checkOutput("rstmid mem_rsp_ready", mem_rsp_ready, 1'b0);
        checkOutput("rstmid busy", busy, 1'b0);
        resetModel();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rstmid post busy", busy, 1'b0);
        checkOutput("rstmid post a_rsp_valid", a_rsp_valid, 1'b0);
        checkOutput("rstmid post grant A", mem_req_tag, {1'b0, a_req_tag});
        runCycle();

        // Randomized traffic against the reference model
        applyReset();
        memAuto = 1;
        for (int c = 0; c < 1500; c++) begin
            applyStimulus();
            runCycle();
        end
        a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 1; b_rsp_ready = 1; mem_req_ready = 1;
        for (int c = 0; c < 200 && (cntA != 0 || cntB != 0); c++) runCycle();
        #1;
        checkOutput("random drained busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
